// File: rtl/norm_list_ctrl.sv
// Sequencer for the linked-list norm-squared datapath: clears it, walks the list
// from the head pointer in word 0, flushes the square/accumulate pipeline and returns the result.
module norm_list_ctrl #(
    parameter int unsigned RD_LAT  = 0,
    parameter int unsigned MAX_LEN = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        DONE_i,
    input  logic [6:0]  LEN,
    input  logic [46:0] NORM2,
    output logic        Load_Add_R,
    output logic        Load_I_R,
    output logic        sel_A1,
    output logic        inc_len,
    output logic        dp_clr_n,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [46:0] norm2,
    output logic [6:0]  len
);

    localparam int unsigned   WW        = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
    localparam logic [WW-1:0] LAT       = WW'(RD_LAT);
    localparam logic [6:0]    LEN_LIMIT = 7'(MAX_LEN);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_HEAD_RD,
        ST_HEAD_LD,
        ST_CHECK,
        ST_XY_RD,
        ST_XY_LD,
        ST_NXT_RD,
        ST_NXT_LD,
        ST_FLUSH1,
        ST_FLUSH2,
        ST_DONE
    } state_t;

    state_t        r_state;
    state_t        w_nxt;
    logic [WW-1:0] r_wait;
    logic [WW-1:0] w_wait_nxt;
    logic          w_rd_ready;
    logic          w_err_nxt;

    logic          r_ld_add;
    logic          r_ld_i;
    logic          r_sel;
    logic          r_inc;
    logic          r_clr_n;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic [46:0]   r_norm2;
    logic [6:0]    r_len;

    logic          w_ld_add;
    logic          w_ld_i;
    logic          w_sel;
    logic          w_inc;
    logic          w_clr_n;
    logic          w_busy;
    logic          w_done;

    assign w_rd_ready = (r_wait == LAT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_wait  <= '0;
        end else begin
            r_state <= w_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    always_comb begin
        w_nxt      = r_state;
        w_wait_nxt = '0;
        w_err_nxt  = r_err;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_nxt     = ST_CLEAR;
                    w_err_nxt = 1'b0;
                end
            end
            ST_CLEAR:   w_nxt = ST_HEAD_RD;
            ST_HEAD_RD: begin
                if (w_rd_ready) w_nxt = ST_HEAD_LD;
                else            w_wait_nxt = r_wait + 1'b1;
            end
            ST_HEAD_LD: w_nxt = ST_CHECK;
            ST_CHECK: begin
                if (DONE_i) begin
                    w_nxt = ST_FLUSH1;
                end else if (LEN == LEN_LIMIT) begin
                    w_nxt     = ST_FLUSH1;
                    w_err_nxt = 1'b1;
                end else begin
                    w_nxt = ST_XY_RD;
                end
            end
            ST_XY_RD: begin
                if (w_rd_ready) w_nxt = ST_XY_LD;
                else            w_wait_nxt = r_wait + 1'b1;
            end
            ST_XY_LD:   w_nxt = ST_NXT_RD;
            ST_NXT_RD: begin
                if (w_rd_ready) w_nxt = ST_NXT_LD;
                else            w_wait_nxt = r_wait + 1'b1;
            end
            ST_NXT_LD:  w_nxt = ST_CHECK;
            ST_FLUSH1:  w_nxt = ST_FLUSH2;
            ST_FLUSH2:  w_nxt = ST_DONE;
            ST_DONE:    w_nxt = ST_IDLE;
            default:    w_nxt = ST_IDLE;
        endcase
    end

    // Control outputs are decoded from the next state and registered, so each
    // pulse lines up with its state and is glitch-free at the datapath.
    always_comb begin
        w_ld_add = (w_nxt == ST_HEAD_LD) || (w_nxt == ST_NXT_LD);
        w_ld_i   = (w_nxt == ST_XY_LD) || (w_nxt == ST_FLUSH1) || (w_nxt == ST_FLUSH2);
        w_sel    = (w_nxt == ST_XY_RD) || (w_nxt == ST_XY_LD);
        w_inc    = (w_nxt == ST_XY_LD);
        w_clr_n  = (w_nxt != ST_CLEAR);
        w_busy   = (w_nxt != ST_IDLE);
        w_done   = (w_nxt == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ld_add <= 1'b0;
            r_ld_i   <= 1'b0;
            r_sel    <= 1'b0;
            r_inc    <= 1'b0;
            r_clr_n  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_norm2  <= '0;
            r_len    <= '0;
        end else begin
            r_ld_add <= w_ld_add;
            r_ld_i   <= w_ld_i;
            r_sel    <= w_sel;
            r_inc    <= w_inc;
            r_clr_n  <= w_clr_n;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_err    <= w_err_nxt;
            // The accumulator holds its final value throughout DONE.
            if (r_state == ST_DONE) begin
                r_norm2 <= NORM2;
                r_len   <= LEN;
            end
        end
    end

    assign Load_Add_R = r_ld_add;
    assign Load_I_R   = r_ld_i;
    assign sel_A1     = r_sel;
    assign inc_len    = r_inc;
    assign dp_clr_n   = r_clr_n;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign norm2      = r_norm2;
    assign len        = r_len;

endmodule

// File: tb/tb_norm_list_ctrl.sv
// Directed bench for norm_list_ctrl: two sequencers (RD_LAT 0 and 1), each driving a
// small integer stand-in of the list datapath; NORM2 = {sum of X^2+Y^2, 9'd0}.
module tb_norm_list_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] mem [0:511];

    logic        start      [2];
    logic        DONE_i     [2];
    logic [6:0]  LEN        [2];
    logic [46:0] NORM2      [2];
    logic        Load_Add_R [2];
    logic        Load_I_R   [2];
    logic        sel_A1     [2];
    logic        inc_len    [2];
    logic        dp_clr_n   [2];
    logic        busy       [2];
    logic        done       [2];
    logic        err        [2];
    logic [46:0] norm2      [2];
    logic [6:0]  len        [2];

    int n_err = 0;
    int n_chk = 0;

    for (genvar g = 0; g < 2; g++) begin : lane
        norm_list_ctrl #(.RD_LAT(g), .MAX_LEN(127)) dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start[g]),
            .DONE_i     (DONE_i[g]),
            .LEN        (LEN[g]),
            .NORM2      (NORM2[g]),
            .Load_Add_R (Load_Add_R[g]),
            .Load_I_R   (Load_I_R[g]),
            .sel_A1     (sel_A1[g]),
            .inc_len    (inc_len[g]),
            .dp_clr_n   (dp_clr_n[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .err        (err[g]),
            .norm2      (norm2[g]),
            .len        (len[g])
        );

        logic [8:0]  addr;
        logic [8:0]  a1;
        logic [31:0] rd0;
        logic [31:0] rd_q;
        logic [31:0] w1;
        logic [15:0] r0, r1;
        logic [31:0] r2, r3;
        logic [37:0] r4;
        logic        dflag;
        logic [6:0]  cnt;
        logic        dprst;

        assign dprst = rst & dp_clr_n[g];
        assign a1    = sel_A1[g] ? addr + 9'd2 : addr;
        assign rd0   = mem[a1];
        always @(posedge clk) rd_q <= rd0;
        assign w1    = (g == 0) ? rd0 : rd_q;

        always @(posedge clk or negedge dprst) begin
            if (!dprst) begin
                addr <= '0; dflag <= 1'b0; cnt <= '0;
                r0 <= '0; r1 <= '0; r2 <= '0; r3 <= '0; r4 <= '0;
            end else begin
                if (Load_Add_R[g]) begin
                    addr  <= w1[8:0];
                    dflag <= (w1[8:0] == 9'd0);
                end
                if (Load_I_R[g]) begin
                    r0 <= w1[31:16];
                    r1 <= w1[15:0];
                    r2 <= r0 * r0;
                    r3 <= r1 * r1;
                    r4 <= r4 + r2 + r3;
                end
                if (inc_len[g]) cnt <= cnt + 7'd1;
            end
        end

        assign DONE_i[g] = dflag;
        assign LEN[g]    = cnt;
        assign NORM2[g]  = {r4, 9'd0};
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic setup_empty();
        mem[0] = 32'd0;
    endtask

    task automatic setup_3node();
        mem[0]     = 32'h010;
        mem[9'h10] = 32'h020; mem[9'h12] = {16'd1, 16'd1};
        mem[9'h20] = 32'h030; mem[9'h22] = {16'd1, 16'd1};
        mem[9'h30] = 32'h000; mem[9'h32] = {16'd1, 16'd1};
    endtask

    task automatic setup_loop();
        mem[0]     = 32'h040;
        mem[9'h40] = 32'h040; mem[9'h42] = {16'd1, 16'd1};
    endtask

    task automatic run_job(input int ln, input bit hold, input int exp_cyc,
                           input logic [6:0] exp_len, input logic [46:0] exp_nrm,
                           input logic exp_err, input int exp_li, input int exp_la,
                           input int exp_inc, input int budget);
        int n = 1, li = 0, la = 0, inc = 0, clr = 0, gap = 0;
        logic err_c1;
        @(negedge clk); start[ln] = 1'b1;
        @(posedge clk); #1;
        if (!hold) start[ln] = 1'b0;
        err_c1 = err[ln];
        while (1) begin
            li  += int'(Load_I_R[ln]);
            la  += int'(Load_Add_R[ln]);
            inc += int'(inc_len[ln]);
            clr += int'(!dp_clr_n[ln]);
            gap += int'(!busy[ln]);
            if (done[ln] || n >= budget) break;
            @(posedge clk); #1; n++;
        end
        check("done_seen",  done[ln], 1);
        check("done_cycle", n, exp_cyc);
        check("err_clr",    err_c1, 0);
        check("err_done",   err[ln], exp_err);
        check("ld_i_cnt",   li, exp_li);
        check("ld_add_cnt", la, exp_la);
        check("inc_cnt",    inc, exp_inc);
        check("clr_cnt",    clr, 1);
        check("busy_gap",   gap, 0);
        @(posedge clk); #1;
        check("done_pulse", done[ln], 0);
        check("busy_after", busy[ln], 0);
        check("norm2",      norm2[ln], exp_nrm);
        check("len",        len[ln], exp_len);
        check("err_hold",   err[ln], exp_err);
    endtask

    localparam logic [46:0] NRM6   = 47'd6 << 9;
    localparam logic [46:0] NRM254 = 47'd254 << 9;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = '0;
        rst = 1'b0;
        start[0] = 1'b0;
        start[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_clr_n", dp_clr_n[i], 1);
            check("rst_outs", {Load_Add_R[i], Load_I_R[i], sel_A1[i], inc_len[i],
                               busy[i], done[i], err[i]}, 0);
            check("rst_res", {norm2[i], len[i]}, 0);
        end
        @(negedge clk); rst = 1'b1;

        setup_empty();
        run_job(0, 0, 7, 7'd0, 47'd0, 1'b0, 2, 1, 0, 100);

        setup_3node();
        run_job(0, 0, 22, 7'd3, NRM6, 1'b0, 5, 4, 3, 100);
        run_job(1, 0, 29, 7'd3, NRM6, 1'b0, 5, 4, 3, 100);

        setup_loop();
        run_job(0, 0, 642, 7'd127, NRM254, 1'b1, 129, 128, 127, 800);

        // start held across two jobs: second must begin only after done
        setup_3node();
        run_job(0, 1, 22, 7'd3, NRM6, 1'b0, 5, 4, 3, 100);
        run_job(0, 1, 22, 7'd3, NRM6, 1'b0, 5, 4, 3, 100);
        @(negedge clk); start[0] = 1'b0;

        // reset in XY_RD of node 2 (cycle 10)
        @(negedge clk); start[0] = 1'b1;
        @(posedge clk); #1; start[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("mid_sel", sel_A1[0], 1);
        #1 rst = 1'b0;
        #1;
        check("mid_clr_n", dp_clr_n[0], 1);
        check("mid_outs", {Load_Add_R[0], Load_I_R[0], sel_A1[0], inc_len[0],
                           busy[0], done[0], err[0]}, 0);
        check("mid_res", {norm2[0], len[0]}, 0);
        @(negedge clk); rst = 1'b1;
        run_job(0, 0, 22, 7'd3, NRM6, 1'b0, 5, 4, 3, 100);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/norm_list_ctrl.md
# norm_list_ctrl

Sequencer for the linked-list norm-squared datapath (`Processing_Unit`). On a `start` request it performs four tasks:
- clears the datapath;
- reads the list head pointer from memory word 0;
- walks each node, loading X/Y and the next pointer;
- flushes the two-stage square/accumulate pipeline, then returns the 47-bit sum of squares and the node count with a one-cycle `done` pulse.

It sits between the system-level requester and `Processing_Unit`, driving all of that unit's control inputs.

## Interface
- `RD_LAT`, default 0: memory read latency in cycles (0 = combinational read); each read state waits `RD_LAT` extra cycles.
- `MAX_LEN`, default 127: node limit; reaching it without end-of-list aborts with `err`.

Ports (name, direction, width, meaning):
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  job request, sampled in IDLE only.
- `DONE_i`  in  1  datapath end-of-list flag (1 = last loaded pointer was 0).
- `LEN`  in  7  datapath link counter.
- `NORM2`  in  47  datapath accumulator ([46:9] mantissa, [8:0] exponent).
- `Load_Add_R`  out  1  load the address register from `mem_word1[8:0]`; registered, single-cycle pulse.
- `Load_I_R`  out  1  advance the X/Y → square → accumulate pipeline; registered pulse.
- `sel_A1`  out  1  0: `address1` = base (pointer read); 1: `address1` = base+2 (X read).
- `inc_len`  out  1  increment the datapath `LEN`.
- `dp_clr_n`  out  1  active-low datapath clear; ANDed with `rst` at the datapath reset pin.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  `MAX_LEN` abort flag; valid with `done`, held until the next accepted `start`.
- `norm2`  out  47  result register, captured in DONE.
- `len`  out  7  node count register, captured in DONE.

## Operation
- All outputs are registered (glitch-free). `Load_Add_R` clocks the datapath `DONE_i` flop directly, so it must be glitch-free.
- Reset values: `dp_clr_n`=1; `norm2`=0, `len`=0; `Load_Add_R`, `Load_I_R`, `sel_A1`, `inc_len`, `busy`, `done`, `err` all 0. The state machine resets to IDLE.
- State sequence:
  - IDLE: `start`=1 → CLEAR; clear `err`.
  - CLEAR: `dp_clr_n`=0 for one cycle. This zeroes the address register, R0–R4 and `LEN`. → HEAD_RD.
  - HEAD_RD: `sel_A1`=0, so `address1`=0. Hold 1+`RD_LAT` cycles. → HEAD_LD.
  - HEAD_LD: `Load_Add_R`=1. → CHECK.
  - CHECK: evaluate in order:
    1. `DONE_i`=1 → FLUSH1.
    2. Otherwise, `LEN`==`MAX_LEN` → set `err`, → FLUSH1.
    3. Otherwise → XY_RD.
  - XY_RD: `sel_A1`=1. Hold 1+`RD_LAT` cycles. → XY_LD.
  - XY_LD: `Load_I_R`=1, `inc_len`=1, `sel_A1`=1. → NXT_RD.
  - NXT_RD: `sel_A1`=0. Hold 1+`RD_LAT` cycles. → NXT_LD.
  - NXT_LD: `Load_Add_R`=1. → CHECK.
  - FLUSH1, FLUSH2: `Load_I_R`=1 in each. This moves the last X/Y through the square and accumulate stages. R0/R1 pick up don't-care data, which never reaches R4.
  - DONE: `norm2`←`NORM2`, `len`←`LEN`, `done`=1. → IDLE.
- Flush is performed even for an empty list. R4 stays 0 because the cleared R2/R3 are 0.
- `start` outside IDLE is ignored. There is no queueing.
- Reset mid-job returns everything to reset values immediately. No `done` is issued.

## Timing
- Start acceptance edge is cycle 0. CLEAR is cycle 1. `done` goes high in cycle 5N+7+`RD_LAT`·(2N+1), for N nodes.
- Empty list, `RD_LAT`=0: `done` in cycle 7. For N=3: cycle 22.
- `busy` is high from cycle 1 through the `done` cycle inclusive. `start` is re-accepted in the cycle after `done`.
- `DONE_i` is sampled in CHECK, one cycle after the `Load_Add_R` pulse.
- `err` abort: `MAX_LEN` XY_LD cycles have occurred, then `done` follows after the 2 flush cycles plus DONE. `len` = `MAX_LEN`.
- `norm2` and `len` hold until the next DONE, or until reset.

## Test plan
- Empty list (word0 = 0), `RD_LAT`=0 → `done` in cycle 7, `len`=0, `norm2`=0, `err`=0, exactly 2 `Load_I_R` pulses.
- 3 nodes at 0x010 → 0x020 → 0x030 → 0, each with X=Y=1.0 → `done` in cycle 22, `len`=3, `norm2` equals the golden model of 6.0. 5 `Load_I_R`, 4 `Load_Add_R`, 3 `inc_len` pulses.
- Self-loop node (next pointer = own base) → `done` with `err`=1, `len`=127.
- `RD_LAT`=1, same 3-node list → `done` in cycle 29, identical `norm2`.
- `start` held high during a job, then two back-to-back jobs → second job accepted only after `done`. Second result equals the first, proving `dp_clr_n` clears.
- `rst` low in XY_RD of node 2 → all outputs 0 in the same cycle, state IDLE. Next job completes correctly.
